// File: rtl/rr_lzc_arbiter_pkg.sv
// Shared types and helpers for rr_lzc_arbiter.
// Round-robin mode is enabled with the macro RR_LZC_ARBITER_FAIR_EN.
package rr_lzc_arbiter_pkg;

  localparam int unsigned MAX_REQ = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Mask with every bit strictly above ptr set; empty when ptr is the top index.
  function automatic logic [MAX_REQ-1:0] above_mask(input int unsigned ptr);
    logic [MAX_REQ-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      m[i] = (i > ptr);
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_lzc_arbiter_lzc.sv
// Zero counter: MODE 0 counts trailing zeros (index of lowest set bit),
// MODE 1 counts leading zeros. empty flags an all-zero input.
module rr_lzc_arbiter_lzc #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MODE  = 0
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     empty
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  // Priority scan; the last hit in loop order wins.
  always_comb begin
    cnt   = '0;
    empty = ~|vec;
    if (MODE == 0) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (vec[i]) cnt = CNT_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (vec[i]) cnt = CNT_W'(int'(WIDTH) - 1 - i);
      end
    end
  end

endmodule

// File: rtl/rr_lzc_arbiter.sv
// Zero-latency arbiter with lock-until-accepted downstream handshake.
// RR_LZC_ARBITER_FAIR_EN defined: round-robin starting above the last winner.
// RR_LZC_ARBITER_FAIR_EN undefined: fixed priority, lowest index wins.
module rr_lzc_arbiter
  import rr_lzc_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic [$clog2(NUM_REQ)-1:0]           idx_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e           state_q;
  logic [IDX_W-1:0] lock_q;
  logic [IDX_W-1:0] fresh_idx;
  logic [IDX_W-1:0] unmasked_idx;
  logic             unmasked_empty;

  rr_lzc_arbiter_lzc #(
    .WIDTH (NUM_REQ),
    .MODE  (0)
  ) u_lzc_unmasked (
    .vec   (req_i),
    .cnt   (unmasked_idx),
    .empty (unmasked_empty)
  );

`ifdef RR_LZC_ARBITER_FAIR_EN
  logic [IDX_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] masked_req;
  logic [IDX_W-1:0]   masked_idx;
  logic               masked_empty;

  assign masked_req = req_i & NUM_REQ'(above_mask(32'(ptr_q)));

  rr_lzc_arbiter_lzc #(
    .WIDTH (NUM_REQ),
    .MODE  (0)
  ) u_lzc_masked (
    .vec   (masked_req),
    .cnt   (masked_idx),
    .empty (masked_empty)
  );

  // Prefer requesters above the last winner, else wrap to the lowest.
  assign fresh_idx = masked_empty ? unmasked_idx : masked_idx;
`else
  assign fresh_idx = unmasked_idx;
`endif

  // Combinational selection, payload mux and grant strobe.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    gnt_o   = '0;
    data_o  = '0;
    if (state_q == LOCKED) begin
      valid_o = 1'b1;
      idx_o   = lock_q;
    end else begin
      valid_o = !unmasked_empty;
      idx_o   = fresh_idx;
    end
    if (valid_o) data_o = data_i[idx_o];
    if (valid_o && ready_i && !rst_i) gnt_o = NUM_REQ'(1) << idx_o;
  end

  // Lock FSM and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
`ifdef RR_LZC_ARBITER_FAIR_EN
      ptr_q   <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_o && !ready_i) begin
            state_q <= LOCKED;
            lock_q  <= idx_o;
          end
        end
        LOCKED: begin
          if (ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef RR_LZC_ARBITER_FAIR_EN
      if (valid_o && ready_i) ptr_q <= idx_o;
`endif
    end
  end

`ifndef SYNTHESIS
  // A locked requester must keep requesting until it is granted.
  locked_req_held : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state_q == LOCKED) |-> req_i[lock_q]
  );
`endif

endmodule

// File: tb/tb_rr_lzc_arbiter.sv
// Self-checking bench for rr_lzc_arbiter (NUM_REQ=4, DATA_WIDTH=32).
// Works in both builds; expectations follow RR_LZC_ARBITER_FAIR_EN.
module tb_rr_lzc_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
`ifdef RR_LZC_ARBITER_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  localparam logic [DW-1:0] D0 = 32'hA0A0_1000;
  localparam logic [DW-1:0] D1 = 32'hB1B1_2001;
  localparam logic [DW-1:0] D2 = 32'hC2C2_3002;
  localparam logic [DW-1:0] D3 = 32'hD3D3_4003;

  logic                   clk;
  logic                   rst_i;
  logic [N-1:0]           req_i;
  logic [N-1:0][DW-1:0]   data_i;
  logic [N-1:0]           gnt_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [DW-1:0]          data_o;
  logic [1:0]             idx_o;

  int n_pass  = 0;
  int n_total = 0;

  rr_lzc_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .gnt_o   (gnt_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .idx_o   (idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  bit m_locked = 1'b0;
  int m_lock   = 0;
  int m_ptr    = N - 1;

  // First requester found walking circularly upward from just past ptr
  // (round-robin), or from index 0 (fixed priority).
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int start;
    start = FAIR ? ptr + 1 : 0;
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  task automatic model_eval(output bit ev, output int eidx, output logic [N-1:0] eg,
                            output logic [DW-1:0] ed);
    bit lk;
    int p;
    lk   = m_locked && !rst_i;
    p    = rst_i ? N - 1 : m_ptr;
    ev   = lk || (req_i != '0);
    eidx = lk ? m_lock : pick(req_i, p);
    eg   = (ev && ready_i && !rst_i) ? N'(1) << eidx : '0;
    ed   = ev ? data_i[eidx] : '0;
  endtask

  // Advance the model on each rising edge.
  always @(posedge clk) begin
    bit ev; int eidx; logic [N-1:0] eg; logic [DW-1:0] ed;
    if (rst_i) begin
      m_locked = 1'b0;
      m_ptr    = N - 1;
    end else begin
      model_eval(ev, eidx, eg, ed);
      if (ev && ready_i) begin
        m_ptr    = eidx;
        m_locked = 1'b0;
      end else if (ev) begin
        m_locked = 1'b1;
        m_lock   = eidx;
      end
    end
  end

  // Compare the DUT against the model every cycle, mid-period.
  always @(negedge clk) begin
    bit ev; int eidx; logic [N-1:0] eg; logic [DW-1:0] ed;
    model_eval(ev, eidx, eg, ed);
    check("mdl_valid", 64'(valid_o), 64'(ev));
    check("mdl_gnt",   64'(gnt_o),   64'(eg));
    check("mdl_data",  64'(data_o),  64'(ed));
    if (ev) check("mdl_idx", 64'(idx_o), 64'(eidx));
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic [N-1:0] r, input logic rd, input logic rs);
    @(posedge clk);
    #1;
    req_i   = r;
    ready_i = rd;
    rst_i   = rs;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input bit ev, input int eidx, input logic [N-1:0] eg);
    check({name, "_valid"}, 64'(valid_o), 64'(ev));
    check({name, "_gnt"},   64'(gnt_o),   64'(eg));
    if (ev) check({name, "_idx"}, 64'(idx_o), 64'(eidx));
  endtask

  initial begin
    int e;
    rst_i   = 1'b1;
    req_i   = '0;
    ready_i = 1'b0;
    data_i[0] = D0;
    data_i[1] = D1;
    data_i[2] = D2;
    data_i[3] = D3;

    // Reset: idle outputs, and no grant while reset is held.
    apply(4'b0000, 1'b0, 1'b1);
    lit("rst_idle", 1'b0, 0, 4'b0000);
    check("rst_data", 64'(data_o), 64'h0);
    apply(4'b1111, 1'b1, 1'b1);
    lit("rst_req", 1'b1, 0, 4'b0000);

    // All requesting, always ready.
    for (int i = 0; i < 8; i++) begin
      apply(4'b1111, 1'b1, 1'b0);
      e = FAIR ? i % 4 : 0;
      lit($sformatf("all_%0d", i), 1'b1, e, 4'(1) << e);
    end
    apply(4'b0000, 1'b1, 1'b0);

    // Lock on requester 2; new lower requester ignored until accepted.
    for (int i = 0; i < 3; i++) begin
      apply(4'b0100, 1'b0, 1'b0);
      lit($sformatf("hold_%0d", i), 1'b1, 2, 4'b0000);
    end
    apply(4'b0101, 1'b1, 1'b0);
    lit("hold_acc", 1'b1, 2, 4'b0100);
    check("hold_data", 64'(data_o), 64'(D2));

    // Bring pointer to 3, then wrap to 0 and back to 3.
    apply(4'b1000, 1'b1, 1'b0);
    lit("to3", 1'b1, 3, 4'b1000);
    apply(4'b1001, 1'b1, 1'b0);
    lit("wrap0", 1'b1, 0, 4'b0001);
    apply(4'b1001, 1'b1, 1'b0);
    e = FAIR ? 3 : 0;
    lit("wrap1", 1'b1, e, 4'(1) << e);

    // Requesters 1 and 3 held.
    for (int i = 0; i < 4; i++) begin
      apply(4'b1010, 1'b1, 1'b0);
      e = (FAIR && (i % 2 == 1)) ? 3 : 1;
      lit($sformatf("pair_%0d", i), 1'b1, e, 4'(1) << e);
    end

    // Lock on 1, higher-priority arrival ignored, reset discards lock.
    apply(4'b0010, 1'b0, 1'b0);
    lit("lk1", 1'b1, 1, 4'b0000);
    apply(4'b0011, 1'b0, 1'b0);
    lit("lk1_keep", 1'b1, 1, 4'b0000);
    check("lk1_data", 64'(data_o), 64'(D1));
    apply(4'b0011, 1'b1, 1'b1);
    lit("lk_rst", 1'b1, 0, 4'b0000);
    apply(4'b1000, 1'b1, 1'b0);
    lit("post_rst", 1'b1, 3, 4'b1000);
    check("post_rst_data", 64'(data_o), 64'(D3));

    // No requests.
    apply(4'b0000, 1'b1, 1'b0);
    lit("none", 1'b0, 0, 4'b0000);
    check("none_data", 64'(data_o), 64'h0);

    // Single requester wins back-to-back.
    for (int i = 0; i < 3; i++) begin
      apply(4'b0100, 1'b1, 1'b0);
      lit($sformatf("single_%0d", i), 1'b1, 2, 4'b0100);
    end

    // Payload change while idle, then a few mixed patterns.
    apply(4'b0000, 1'b1, 1'b0);
    data_i[0] = 32'h0F0F_5555;
    data_i[3] = 32'h1234_ABCD;
    apply(4'b1001, 1'b0, 1'b0);
    apply(4'b1001, 1'b1, 1'b0);
    apply(4'b1001, 1'b1, 1'b0);
    apply(4'b0110, 1'b1, 1'b0);
    apply(4'b0000, 1'b0, 1'b0);

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
